data_cache: RTL
===============

# data_cache

Direct-mapped, write-back, write-allocate data cache between the RV32IM MEM stage and the 128-bit-block data memory. Serves byte, halfword and word loads and stores from a local line array. Stalls the pipeline through BUSYWAIT on a miss. On a miss it writes back a dirty victim block, then fetches the missing 16-byte block.

## Interface
- INDEX_BITS, 3: number of index bits; the cache has 2^INDEX_BITS lines of 16 bytes each.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request; takes priority if both READ and WRITE are high.
- FUNCT3  in  3  access type.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- ADDRESS  in  32  CPU byte address.
- WRITEDATA  in  32  store data; the lane comes from the low bits.
- READDATA  out  32  load result, sign- or zero-extended.
- BUSYWAIT  out  1  stall to the pipeline.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  28  block address, equal to byte address[31:4].
- MEM_WRITEDATA  out  128  victim block; byte k sits at bits [8k+7:8k].
- MEM_READDATA  in  128  fetched block, same byte layout.
- MEM_BUSYWAIT  in  1  memory busy; goes high while a request is held and low when the access completes.

## Operation
- Address split:
  - offset = ADDRESS[3:0]
  - index = ADDRESS[3+INDEX_BITS:4]
  - tag = ADDRESS[31:4+INDEX_BITS]
- Per line: valid, dirty, tag, 128-bit data.
- Hit = request && valid[index] && tag match.
- Alignment: halfword accesses ignore ADDRESS[0]; word accesses ignore ADDRESS[1:0]. No misalignment trap.
- Read hit: READDATA is combinational from the selected lane with extension per FUNCT3. No state change.
- Write hit: at the clock edge, update only the addressed byte, halfword or word lane and set dirty. Other bytes are unchanged.
- States:
  - IDLE: on a miss with a dirty victim, go to WRITEBACK; on a miss with a clean or invalid victim, go to ALLOCATE.
  - WRITEBACK: hold MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=victim data. On an edge with MEM_BUSYWAIT=0, go to ALLOCATE.
  - ALLOCATE: hold MEM_READ=1, MEM_ADDRESS=ADDRESS[31:4]. On an edge with MEM_BUSYWAIT=0, load MEM_READDATA into the line, set the tag, set valid=1, clear dirty, and go to IDLE.
  - Back in IDLE the held request now hits and completes normally; a store merges into the fetched block and sets dirty.
- MEM_READ and MEM_WRITE are never high together. Both are registered state decodes.
- BUSYWAIT = (READ||WRITE) && !(state==IDLE && hit).
- The CPU holds READ, WRITE, FUNCT3, ADDRESS and WRITEDATA stable while BUSYWAIT=1.
- READDATA is 0 when there is no read hit.

## Timing
- Reset values: state IDLE; all valid=0 and dirty=0; MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0; BUSYWAIT=0 with no request; READDATA=0. Line data and tags are don't-care.
- Hit: zero stall cycles. BUSYWAIT stays low; a store commits at the same edge.
- Clean miss: BUSYWAIT rises in the request cycle. ALLOCATE starts at the next edge and lasts until the memory completes. One IDLE hit cycle then drops BUSYWAIT.
- Dirty miss: same as a clean miss plus the WRITEBACK phase.
- RESET asserted mid-miss: the FSM goes to IDLE immediately and MEM_READ/MEM_WRITE drop asynchronously. A partial write-back is abandoned and dirty data is lost. The next access misses.
- READ and WRITE both high: treated as a store.
- No request in IDLE: no state change, and memory is not touched.

## Test plan
- Reset, then LW 0x00000040, memory block 4 word1... word0 = 0x11223344 -> MEM_READ with MEM_ADDRESS 0x0000004. After MEM_BUSYWAIT falls, READDATA = 0x11223344 and BUSYWAIT falls one cycle later.
- SW 0xDEADBEEF to 0x44, then LW 0x44 -> no MEM_READ/MEM_WRITE, zero stalls, READDATA = 0xDEADBEEF.
- Loads from that word:
  - LB 0x47 -> 0xFFFFFFDE
  - LBU 0x47 -> 0x000000DE
  - LH 0x46 -> 0xFFFFDEAD
  - LHU 0x46 -> 0x0000DEAD
- SB 0x12 to 0x45, then LW 0x44 -> 0xDEAD12EF.
- LW 0xC0 (same index 4, different tag) -> MEM_WRITE with MEM_ADDRESS 0x0000004 and bytes 4..7 = EF 12 AD DE. Then MEM_READ with MEM_ADDRESS 0x000000C, then a hit.
- Assert RESET during ALLOCATE -> MEM_READ low in the same cycle. Re-reading 0xC0 misses again.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and
// 128-bit block memory. A miss stalls the CPU while a dirty victim is written back and the block fetched.
module data_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         READ,
    input  logic         WRITE,
    input  logic [2:0]   FUNCT3,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITEDATA,
    output logic [31:0]  READDATA,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    // state     | meaning
    // S_IDLE    | serve hits; detect misses
    // S_WRITEBACK | dirty victim block is being written to memory
    // S_ALLOCATE  | missing block is being fetched into the line
    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;
    state_t state_q, state_d;

    logic [LINES-1:0]    valid_q, dirty_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [127:0]        data_q [LINES];

    logic [3:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  request, hit, in_idle, store_hit, fill;
    logic [127:0]          cur_line, line_st;
    logic [31:0]           rd_word, st_word;
    logic [15:0]           rd_half;
    logic [7:0]            rd_byte;

    assign offset    = ADDRESS[3:0];
    assign index     = ADDRESS[3+INDEX_BITS:4];
    assign tag       = ADDRESS[31:4+INDEX_BITS];
    assign request   = READ | WRITE;
    assign in_idle   = (state_q == S_IDLE);
    assign hit       = request && valid_q[index] && (tag_q[index] == tag);
    assign BUSYWAIT  = request && !(in_idle && hit);
    assign store_hit = WRITE && in_idle && hit;
    assign fill      = (state_q == S_ALLOCATE) && !MEM_BUSYWAIT;

    assign cur_line = data_q[index];
    assign rd_word  = cur_line[{offset[3:2], 5'b0} +: 32];
    assign rd_half  = offset[1] ? rd_word[31:16] : rd_word[15:0];
    assign rd_byte  = rd_word[{offset[1:0], 3'b0} +: 8];

    always_comb begin
        READDATA = '0;
        if (READ && !WRITE && in_idle && hit) begin
            case (FUNCT3)
                3'b000:  READDATA = {{24{rd_byte[7]}}, rd_byte};
                3'b001:  READDATA = {{16{rd_half[15]}}, rd_half};
                3'b100:  READDATA = {24'b0, rd_byte};
                3'b101:  READDATA = {16'b0, rd_half};
                default: READDATA = rd_word;
            endcase
        end
    end

    // Merge the store lane into the selected word, then into the line.
    always_comb begin
        st_word = rd_word;
        case (FUNCT3[1:0])
            2'b00:   st_word[{offset[1:0], 3'b0} +: 8] = WRITEDATA[7:0];
            2'b01:   st_word[{offset[1], 4'b0} +: 16]  = WRITEDATA[15:0];
            default: st_word = WRITEDATA;
        endcase
        line_st = cur_line;
        line_st[{offset[3:2], 5'b0} +: 32] = st_word;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (request && !hit)
                    state_d = (valid_q[index] && dirty_q[index]) ? S_WRITEBACK : S_ALLOCATE;
            end
            S_WRITEBACK: if (!MEM_BUSYWAIT) state_d = S_ALLOCATE;
            S_ALLOCATE:  if (!MEM_BUSYWAIT) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        case (state_q)
            S_WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[index], index};
                MEM_WRITEDATA = cur_line;
            end
            S_ALLOCATE: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[31:4];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[index] <= 1'b1;
        end
    end

    // Line payload and tags need no reset; valid_q qualifies them.
    always_ff @(posedge CLK) begin
        if (fill) begin
            data_q[index] <= MEM_READDATA;
            tag_q[index]  <= tag;
        end else if (store_hit) begin
            data_q[index] <= line_st;
        end
    end
endmodule
